// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared types and default widths for the sprite object and its testbench.
//   COORD_W     : default screen coordinate width (640x480 frame fits in 10 bits)
//   PIX_W       : default pixel colour width (RGB888)
//   coord_t     : screen coordinate
//   pixel_t     : pixel colour
//   pos_state_t : position-update FSM state (IDLE, PENDING)
package sprite_pkg;

  localparam int COORD_W = 10;
  localparam int PIX_W   = 24;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0]   pixel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pos_state_t;

endpackage

// File: rtl/sprite_obj_if.sv
// sprite_obj_if
// Groups the scan, position, bitmap-write, key and result signals of one
// sprite object.
//   master modport : pixel pipeline side; drives scan/position/write/key,
//                    receives hit and pix_out
//   slave modport  : sprite side; the reverse
// Optional macro SPRITE_MIRROR_EN adds mirror_h / mirror_v.
interface sprite_obj_if #(
  parameter int COORD_W = 10,
  parameter int PIX_W   = 24,
  parameter int SPR_W   = 8,
  parameter int SPR_H   = 8
);

  localparam int WXW = $clog2(SPR_W);
  localparam int WYW = $clog2(SPR_H);

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               scan_vld;
  logic               frame_start;
  logic               set_pos;
  logic [COORD_W-1:0] new_x;
  logic [COORD_W-1:0] new_y;
  logic               wr_en;
  logic [WXW-1:0]     wr_x;
  logic [WYW-1:0]     wr_y;
  logic [PIX_W-1:0]   wr_data;
  logic               key_en;
  logic [PIX_W-1:0]   key;
  logic               active;
`ifdef SPRITE_MIRROR_EN
  logic               mirror_h;
  logic               mirror_v;
`endif
  logic               hit;
  logic [PIX_W-1:0]   pix_out;

  modport master (
    output x, y, scan_vld, frame_start, set_pos, new_x, new_y,
    output wr_en, wr_x, wr_y, wr_data, key_en, key, active,
`ifdef SPRITE_MIRROR_EN
    output mirror_h, mirror_v,
`endif
    input  hit, pix_out
  );

  modport slave (
    input  x, y, scan_vld, frame_start, set_pos, new_x, new_y,
    input  wr_en, wr_x, wr_y, wr_data, key_en, key, active,
`ifdef SPRITE_MIRROR_EN
    input  mirror_h, mirror_v,
`endif
    output hit, pix_out
  );

endinterface

// File: rtl/sprite_ram.sv
// sprite_ram
// Bitmap storage: one synchronous write port and one synchronous read port.
// A read and a write to the same address on the same edge returns the old
// data. No reset, so it maps onto distributed RAM.
//   clk     : clock
//   we_i    : write strobe
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (sampled on the rising edge)
//   rdata_o : read data, valid one cycle after raddr_i
module sprite_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Both ports in one block; the non-blocking read picks up the pre-write
  // contents when the addresses collide.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sprite_obj.sv
// sprite_obj
// One sprite for the pixel pipeline: an SPR_W x SPR_H bitmap placed at a
// frame-synchronised screen position. For each scan coordinate it reports,
// one cycle later, whether the sprite covers it and with which colour.
//   clk   : pixel clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sprite_obj_if.slave (scan, position, bitmap write, key, hit/pix_out)
// Optional macro SPRITE_MIRROR_EN enables horizontal/vertical read mirroring.
module sprite_obj
  import sprite_pkg::*;
#(
  parameter int COORD_W = sprite_pkg::COORD_W,
  parameter int PIX_W   = sprite_pkg::PIX_W,
  parameter int SPR_W   = 8,
  parameter int SPR_H   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sprite_obj_if.slave bus
);

  localparam int WXW = $clog2(SPR_W);
  localparam int WYW = $clog2(SPR_H);
  localparam int AW  = WXW + WYW;
  localparam logic [COORD_W:0] SPR_W_EXT = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0] SPR_H_EXT = (COORD_W+1)'(SPR_H);

  pos_state_t         state_q;
  logic [COORD_W-1:0] cur_x_q, cur_y_q;
  logic [COORD_W-1:0] sh_x_q, sh_y_q;

  // Position FSM. set_pos always refreshes the shadow; the live position only
  // moves on frame_start so a frame is never drawn with a half-updated
  // position. A simultaneous set_pos + frame_start commits the new request
  // directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      sh_x_q  <= '0;
      sh_y_q  <= '0;
    end else begin
      if (bus.set_pos && bus.frame_start) begin
        sh_x_q  <= bus.new_x;
        sh_y_q  <= bus.new_y;
        cur_x_q <= bus.new_x;
        cur_y_q <= bus.new_y;
        state_q <= IDLE;
      end else if (bus.set_pos) begin
        sh_x_q  <= bus.new_x;
        sh_y_q  <= bus.new_y;
        state_q <= PENDING;
      end else if (bus.frame_start && state_q == PENDING) begin
        cur_x_q <= sh_x_q;
        cur_y_q <= sh_y_q;
        state_q <= IDLE;
      end
    end
  end

  // Bounds test one bit wider than the screen so a sprite hanging off the
  // right/bottom edge cannot wrap around and appear at coordinate 0.
  logic [COORD_W:0] x_ext, y_ext, cx_ext, cy_ext;
  logic             in_x, in_y;

  assign x_ext  = {1'b0, bus.x};
  assign y_ext  = {1'b0, bus.y};
  assign cx_ext = {1'b0, cur_x_q};
  assign cy_ext = {1'b0, cur_y_q};
  assign in_x   = (x_ext >= cx_ext) && (x_ext < cx_ext + SPR_W_EXT);
  assign in_y   = (y_ext >= cy_ext) && (y_ext < cy_ext + SPR_H_EXT);

  // Sprite-local offset; only the low bits of the difference matter and they
  // depend only on the low bits of the operands.
  logic [WXW-1:0] dx, rd_col;
  logic [WYW-1:0] dy, rd_row;

  assign dx = bus.x[WXW-1:0] - cur_x_q[WXW-1:0];
  assign dy = bus.y[WYW-1:0] - cur_y_q[WYW-1:0];

  // With power-of-two sizes, SIZE-1-d is simply the bitwise inverse of d.
`ifdef SPRITE_MIRROR_EN
  assign rd_col = bus.mirror_h ? ~dx : dx;
  assign rd_row = bus.mirror_v ? ~dy : dy;
`else
  assign rd_col = dx;
  assign rd_row = dy;
`endif

  logic [AW-1:0]    rd_addr, wr_addr;
  logic [PIX_W-1:0] rd_data;
  logic             raw_hit_d;

  assign rd_addr   = {rd_row, rd_col};
  assign wr_addr   = {bus.wr_y, bus.wr_x};
  assign raw_hit_d = bus.scan_vld & bus.active & in_x & in_y;

  sprite_ram #(
    .DEPTH (SPR_W * SPR_H),
    .AW    (AW),
    .DW    (PIX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (bus.wr_en),
    .waddr_i (wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  logic             raw_hit_q;
  logic             key_en_q;
  logic [PIX_W-1:0] key_q;
  logic [PIX_W-1:0] pix_q;

  // Pipeline stage alongside the RAM read. The key is captured with the
  // coordinate so the transparency test matches the pixel being read.
  // pix_q keeps the last covered colour for cycles without a raw hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_hit_q <= 1'b0;
      key_en_q  <= 1'b0;
      key_q     <= '0;
      pix_q     <= '0;
    end else begin
      raw_hit_q <= raw_hit_d;
      key_en_q  <= bus.key_en;
      key_q     <= bus.key;
      if (raw_hit_q) begin
        pix_q <= rd_data;
      end
    end
  end

  // Outputs are built only from the registers of this stage, so they carry
  // the one-cycle latency and clear together with raw_hit_q on reset.
  assign bus.hit     = raw_hit_q & ~(key_en_q & (rd_data == key_q));
  assign bus.pix_out = raw_hit_q ? rd_data : pix_q;

endmodule

// File: doc/sprite_obj.md
# sprite_obj

Parametrised sprite object for the pixel pipeline: holds an SPR_W×SPR_H bitmap and an on-screen position, and for each scan coordinate reports whether the sprite covers it and with which colour. It replaces the fixed 8×8, 24-bit object. Over that object it adds:
- a registered hit output;
- frame-synchronised (tear-free) position updates;
- a transparency colour key;
- sprite-local write addressing.

Several instances sit in parallel ahead of the compositor/priority mux that drives the VGA output.

## Interface
- COORD_W, 10, screen coordinate width (640×480 frame)
- PIX_W, 24, pixel colour width (RGB888)
- SPR_W, 8, sprite width in pixels; power of two, 2..64
- SPR_H, 8, sprite height in pixels; power of two, 2..64
- clk  in  1  single system/pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- x, y  in  COORD_W each  current scan coordinate
- scan_vld  in  1  x/y valid this cycle
- frame_start  in  1  one-cycle pulse at start of frame; commits pending position
- set_pos  in  1  request position change
- new_x, new_y  in  COORD_W each  requested upper-left corner
- wr_en  in  1  bitmap write strobe
- wr_x  in  log2(SPR_W)  sprite-local write column
- wr_y  in  log2(SPR_H)  sprite-local write row
- wr_data  in  PIX_W  pixel to write
- key_en  in  1  enable transparency key
- key  in  PIX_W  transparent colour
- active  in  1  sprite enabled
- hit  out  1  registered: sprite covers the previous cycle's coordinate
- pix_out  out  PIX_W  registered colour; valid when hit=1

## Operation
- Position control uses a two-state FSM, IDLE and PENDING.
  - In either state, set_pos captures new_x/new_y into shadow registers and moves the FSM to PENDING.
  - frame_start in PENDING copies shadow to live position (cur_x, cur_y) and returns to IDLE.
  - frame_start in IDLE does nothing.
  - set_pos and frame_start in the same cycle: the new_x/new_y of that cycle commit directly to live. FSM ends in IDLE.
- Hit test is done in COORD_W+1 bits, so a sprite near the right or bottom edge never wraps to coordinate 0.
  - in_x = x ≥ cur_x and x < cur_x+SPR_W.
  - in_y is the same using y, cur_y, SPR_H.
- Bitmap address = {y−cur_y, x−cur_x}, truncated to log2(SPR_H) and log2(SPR_W) bits.
- Write address = {wr_y, wr_x}, independent of position.
- Raw hit = scan_vld & active & in_x & in_y.
- Final hit = raw hit & !(key_en & pixel == key).
- pix_out updates only when raw hit is 1, otherwise it holds. Transparent pixels therefore still load pix_out, but hit=0.
- The bitmap is not reset; contents are undefined until written.
- Reset values:
  - hit = 0, pix_out = 0.
  - cur_x, cur_y = 0 and shadow = 0.
  - FSM = IDLE.

## Timing
- Latency of one cycle: coordinate sampled at edge N gives hit/pix_out from edge N+1.
- Position committed at edge N applies to coordinates sampled from edge N+1 onward.
- A write at edge N is visible to reads sampled from edge N+1.
- A read and a write to the same address at the same edge: the read returns the old data.
- Deasserting rst_n mid-frame clears hit immediately, without waiting for the clock, and discards any pending position.
- wr_en, set_pos and scan are independent and may all occur in the same cycle.

## Configuration
- SPRITE_MIRROR_EN defined: adds inputs mirror_h and mirror_v.
  - mirror_h sets read column = SPR_W−1−dx; mirror_v sets read row = SPR_H−1−dy.
  - Both are sampled with the scan coordinate. The write path is unaffected.
- SPRITE_MIRROR_EN undefined: the ports are absent and the read address is unmirrored.

## Structure
- Package sprite_pkg holds:
  - COORD_W and PIX_W defaults;
  - typedefs coord_t and pixel_t;
  - FSM state enum pos_state_t {IDLE, PENDING}.
- Sub-module sprite_ram: SPR_W·SPR_H × PIX_W memory with one synchronous read port and one synchronous write port, read-old-data on collision, no reset; inferable as distributed RAM.

## Test plan
- Reset, write pixel (2,3)=0xFF0000, set_pos (100,50), frame_start, scan (102,53) -> next cycle hit=1, pix_out=0xFF0000; scan (108,53) -> hit=0.
- set_pos (200,200) mid-frame without frame_start -> scan (100,50) still hits, (200,200) misses; after frame_start the reverse holds.
- set_pos (300,10) and frame_start in the same cycle -> position live next cycle, FSM IDLE; a later frame_start changes nothing.
- Position (636,476) with SPR=8 -> (638,478) hits; (0,0) through (3,3) never hit (no wrap).
- key_en=1, key=0x000000, pixel (0,0)=0 -> scanning that pixel gives hit=0; with key_en=0 it gives hit=1.
- Pull rst_n low while a position is pending and hit=1 -> hit=0 asynchronously; after release, frame_start leaves position at (0,0).
